// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, opcodes and fetch state type
//
// Purpose: constants shared by the fetch stage and the decoder.
//   CPU_PC_WIDTH    : program counter / instruction address width
//   CPU_INSTR_WIDTH : instruction word width
//   HALT_ENCODING   : opcode that stops fetch (decoder uses it too)
//   fetch_state_t   : fetch FSM states {RUN, HALT}
package cpu_pkg;

    localparam int CPU_PC_WIDTH    = 8;
    localparam int CPU_INSTR_WIDTH = 8;

    localparam logic [CPU_INSTR_WIDTH-1:0] HALT_ENCODING = 8'hFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, IF/ID register and HALT FSM
//
// Purpose: owns the program counter, drives it to the combinational
// instruction memory and captures the returned word into the IF/ID register.
// Supports stall, branch redirect with flush, and a terminal HALT state.
//
// Ports:
//   clk           in  : rising-edge clock
//   reset         in  : synchronous, active-high
//   pc            out : registered fetch address to instruction memory
//   instruction   in  : memory read data, combinational from pc
//   stall         in  : downstream hold request
//   branch_valid  in  : redirect request from execute
//   branch_target in  : redirect address
//   if_instr      out : IF/ID instruction register
//   if_pc         out : address of if_instr
//   if_valid      out : if_instr is a real instruction, not a bubble
//   halted        out : high while in HALT
//   fetch_count   out : issued-instruction count, saturating at 16'hFFFF
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                     PC_WIDTH    = CPU_PC_WIDTH,
    parameter int                     INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_ENCODING)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   stall,
    input  logic                   branch_valid,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_valid,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    localparam logic [15:0] FETCH_COUNT_MAX = 16'hFFFF;

    fetch_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_instr    <= '0;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_valid) begin
                        // Redirect flushes the word in flight; the stale
                        // if_instr/if_pc stay put but are marked invalid.
                        pc       <= branch_target;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_instr <= instruction;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        if (fetch_count != FETCH_COUNT_MAX) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (instruction == HALT_INSTR) begin
                            // HALT itself is issued; pc parks on its address.
                            // halted rises together with the HALT word in IF/ID.
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                    // stall alone: everything holds
                end
                HALT: begin
                    // Terminal: only reset leaves; stall/branch are ignored.
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic [7:0]  instruction;
    logic        stall;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic [7:0]  if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_pc, m_instr, m_ipc, m_valid, m_halted, m_count;

    always #5 clk = ~clk;

    assign instruction = mem[pc];

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit r, input bit s, input bit bv, input int bt);
        int fetched;
        fetched = mem[m_pc];
        if (r) begin
            m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_count = 0;
        end else if (m_halted != 0) begin
            m_valid = 0;
        end else if (bv) begin
            m_pc = bt; m_valid = 0;
        end else if (!s) begin
            m_instr = fetched;
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_count < 65535) m_count = m_count + 1;
            if (fetched == 8'hFF) m_halted = 1;
            else m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},          32'(pc),          32'(m_pc));
        check({tag, ".if_instr"},    32'(if_instr),    32'(m_instr));
        check({tag, ".if_pc"},       32'(if_pc),       32'(m_ipc));
        check({tag, ".if_valid"},    32'(if_valid),    32'(m_valid));
        check({tag, ".halted"},      32'(halted),      32'(m_halted));
        check({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_count));
    endtask

    // Called at a negedge: drive inputs, take one rising edge, advance the
    // model, then sample on the following negedge.
    task automatic cycle(input string tag, input bit r, input bit s, input bit bv,
                         input int bt, input bit chk = 1'b1);
        reset         = r;
        stall         = s;
        branch_valid  = bv;
        branch_target = 8'(bt);
        @(posedge clk);
        model_step(r, s, bv, bt);
        @(negedge clk);
        if (chk) compare_all(tag);
    endtask

    function automatic logic [7:0] rand_non_halt();
        return 8'($urandom_range(0, 254));
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
        m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = rand_non_halt();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        @(negedge clk);

        // reset for 2 cycles
        cycle("reset0", 1, 0, 0, 0);
        cycle("reset1", 1, 0, 0, 0);
        check("reset.pc",          32'(pc), 32'h0);
        check("reset.if_valid",    32'(if_valid), 32'h0);
        check("reset.halted",      32'(halted), 32'h0);
        check("reset.fetch_count", 32'(fetch_count), 32'h0);

        // sequential fetch
        for (int k = 0; k < 4; k++) begin
            cycle("seq", 0, 0, 0, 0);
            check("seq.if_instr", 32'(if_instr), 32'((k + 1) * 8'h11));
            check("seq.if_pc",    32'(if_pc),    32'(k));
            check("seq.if_valid", 32'(if_valid), 32'h1);
        end
        check("seq.fetch_count", 32'(fetch_count), 32'd4);

        // go back to pc=2 and stall there for 3 cycles
        cycle("br2", 0, 0, 1, 2);
        for (int k = 0; k < 3; k++) begin
            cycle("stall", 0, 1, 0, 0);
            check("stall.pc",          32'(pc), 32'h2);
            check("stall.fetch_count", 32'(fetch_count), 32'd4);
        end
        cycle("resume", 0, 0, 0, 0);
        check("resume.if_instr", 32'(if_instr), 32'h33);
        check("resume.if_pc",    32'(if_pc), 32'h2);

        // branch and stall together
        cycle("brstall", 0, 1, 1, 5);
        check("brstall.pc",       32'(pc), 32'h5);
        check("brstall.if_valid", 32'(if_valid), 32'h0);
        cycle("brtgt", 0, 0, 0, 0);
        check("brtgt.if_instr", 32'(if_instr), 32'(mem[5]));
        check("brtgt.if_valid", 32'(if_valid), 32'h1);

        // wrap FE -> FF -> 00
        cycle("brFE", 0, 0, 1, 8'hFE);
        for (int k = 0; k < 3; k++) begin
            cycle("wrap", 0, 0, 0, 0);
            check("wrap.if_pc",    32'(if_pc), 32'((8'hFE + k) % 256));
            check("wrap.if_valid", 32'(if_valid), 32'h1);
        end

        // halt at mem[3]
        mem[3] = 8'hFF;
        cycle("rst_h", 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle("pre_h", 0, 0, 0, 0);
        cycle("cap_h", 0, 0, 0, 0);
        check("cap_h.if_instr", 32'(if_instr), 32'hFF);
        check("cap_h.if_valid", 32'(if_valid), 32'h1);
        cycle("halt_br", 0, 0, 1, 8'h40);
        check("halt.halted",   32'(halted), 32'h1);
        check("halt.if_valid", 32'(if_valid), 32'h0);
        check("halt.pc",       32'(pc), 32'h3);
        cycle("halt_st", 0, 1, 0, 0);
        cycle("halt_run", 0, 0, 0, 0);

        // reset while halted
        cycle("rst_in_halt", 1, 0, 1, 8'h20);
        check("rst_in_halt.halted",      32'(halted), 32'h0);
        check("rst_in_halt.fetch_count", 32'(fetch_count), 32'h0);
        cycle("pre_st", 0, 0, 0, 0);
        cycle("st", 0, 1, 0, 0);
        // reset while stall held
        cycle("rst_in_stall", 1, 1, 0, 0);
        check("rst_in_stall.pc",       32'(pc), 32'h0);
        check("rst_in_stall.if_valid", 32'(if_valid), 32'h0);

        // randomized stimulus against the model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : rand_non_halt();
        for (int k = 0; k < 400; k++) begin
            cycle("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 255));
        end

        // counter saturation
        for (int i = 0; i < 256; i++) mem[i] = rand_non_halt();
        cycle("rst_sat", 1, 0, 0, 0);
        for (int k = 0; k < 65540; k++) cycle("sat", 0, 0, 0, 0, 1'b0);
        compare_all("sat");
        check("sat.fetch_count", 32'(fetch_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
